// File: rtl/audio_pkg.sv
// Shared audio constants and sample types. The clock divider uses them too.
package audio_pkg;

    localparam int SYS_CLK_HZ     = 100_000_000;
    localparam int MCLK_DIV       = 8;
    localparam int MCLK_PER_FRAME = 256;

    typedef logic signed [15:0] sample_t;

    typedef struct packed {
        sample_t l;
        sample_t r;
    } stereo_t;

endpackage

// File: rtl/i2s_timing.sv
// I2S timing: one free-running frame counter. All DAC clocks, the slot index
// and the serializer strobes are decoded from it.
module i2s_timing #(
    parameter int MCLK_DIV       = 8,
    parameter int MCLK_PER_FRAME = 256,
    parameter int SLOT_W         = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      mclk,
    output logic                      sclk,
    output logic                      lrck,
    output logic                      frame_end,
    output logic                      bit_edge,
    output logic [$clog2(SLOT_W)-1:0] slot_next,
    output logic                      lrck_next
);

    localparam int FW = $clog2(MCLK_DIV * MCLK_PER_FRAME);
    localparam int MB = $clog2(MCLK_DIV) - 1;
    localparam int SB = FW - $clog2(2 * SLOT_W) - 1;
    localparam int SW = $clog2(SLOT_W);

    logic [FW-1:0] cnt;
    logic [FW-1:0] cnt_nxt;

    assign cnt_nxt = cnt + FW'(1);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the values from before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

    assign mclk      = cnt[MB];
    assign sclk      = cnt[SB];
    assign lrck      = cnt[FW-1];
    assign frame_end = &cnt;
    assign bit_edge  = &cnt[SB:0];

    // Slot and channel that become current after this edge; the serializer
    // loads its bit for the new slot on the same edge SCLK falls.
    assign slot_next = cnt_nxt[FW-2 -: SW];
    assign lrck_next = cnt_nxt[FW-1];

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: valid/ready sample intake, one holding register, and an
// MSB-first serializer. Define I2S_TX_UNDERFLOW_CNT_EN to add underflow_cnt.
module i2s_tx #(
    parameter int MCLK_DIV       = audio_pkg::MCLK_DIV,
    parameter int MCLK_PER_FRAME = audio_pkg::MCLK_PER_FRAME,
    parameter int SLOT_W         = 32,
    parameter int SAMPLE_W       = $bits(audio_pkg::sample_t)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] s_left,
    input  logic [SAMPLE_W-1:0] s_right,
    input  logic                s_valid,
    output logic                s_ready,
    output logic                mclk,
    output logic                sclk,
    output logic                lrck,
    output logic                sdata,
    output logic                underflow
`ifdef I2S_TX_UNDERFLOW_CNT_EN
    ,
    output logic [15:0]         underflow_cnt
`endif
);

    localparam int SW = $clog2(SLOT_W);

    logic          frame_end;
    logic          bit_edge;
    logic          lrck_next;
    logic [SW-1:0] slot_next;

    logic [SAMPLE_W-1:0] hold_l, hold_r;
    logic [SAMPLE_W-1:0] act_l, act_r;
    logic [SAMPLE_W-1:0] word;
    logic                hold_v;
    logic                sdata_d;

    i2s_timing #(
        .MCLK_DIV       (MCLK_DIV),
        .MCLK_PER_FRAME (MCLK_PER_FRAME),
        .SLOT_W         (SLOT_W)
    ) u_timing (
        .clk       (clk),
        .rst       (rst),
        .mclk      (mclk),
        .sclk      (sclk),
        .lrck      (lrck),
        .frame_end (frame_end),
        .bit_edge  (bit_edge),
        .slot_next (slot_next),
        .lrck_next (lrck_next)
    );

    assign s_ready   = !hold_v;
    assign underflow = frame_end && !hold_v;

    // A transfer can only land while hold_v is 0, so it never collides with
    // the frame-end consume; on an underflow boundary it simply refills hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_v <= 1'b0;
            act_l  <= '0;
            act_r  <= '0;
        end else begin
            if (frame_end) begin
                if (hold_v) begin
                    act_l  <= hold_l;
                    act_r  <= hold_r;
                    hold_v <= 1'b0;
                end else begin
                    act_l <= '0;
                    act_r <= '0;
                end
            end
            if (s_valid && s_ready) begin
                hold_v <= 1'b1;
            end
        end
    end

    // NOTE: the holding data has no reset; hold_v qualifies it, so resetting
    // the data bits would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (s_valid && s_ready) begin
            hold_l <= s_left;
            hold_r <= s_right;
        end
    end

    assign word = lrck_next ? act_r : act_l;

    // NOTE: sdata_d gets its default before the loop so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        sdata_d = 1'b0;
        for (int i = 0; i < SAMPLE_W; i++) begin
            if (slot_next == SW'(SAMPLE_W - i)) begin
                sdata_d = word[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sdata <= 1'b0;
        end else if (bit_edge) begin
            sdata <= sdata_d;
        end
    end

`ifdef I2S_TX_UNDERFLOW_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            underflow_cnt <= '0;
        end else if (underflow && underflow_cnt != 16'hFFFF) begin
            underflow_cnt <= underflow_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx: a frame-level scoreboard predicts SDATA,
// s_ready and underflow from the samples handed to the DUT.
module tb_i2s_tx;
    import audio_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] s_left, s_right;
    logic        s_valid;
    logic        s_ready, mclk, sclk, lrck, sdata, underflow;
`ifdef I2S_TX_UNDERFLOW_CNT_EN
    logic [15:0] underflow_cnt;
`endif

    i2s_tx dut (
        .clk       (clk),
        .rst       (rst),
        .s_left    (s_left),
        .s_right   (s_right),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .mclk      (mclk),
        .sclk      (sclk),
        .lrck      (lrck),
        .sdata     (sdata),
        .underflow (underflow)
`ifdef I2S_TX_UNDERFLOW_CNT_EN
        ,
        .underflow_cnt (underflow_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Frame position model: 2048 clk per frame, restarting at 0 on reset.
    logic [10:0] tb_cnt;
    always @(posedge clk) begin
        if (rst) tb_cnt <= '0;
        else     tb_cnt <= tb_cnt + 11'd1;
    end

    // Scoreboard: holds the sample pair the DUT's holding register should contain.
    stereo_t     sb_q[$];
    logic        mon_en = 1'b0;
    logic [15:0] exp_l = '0, exp_r = '0, obs_l = '0, obs_r = '0;
    logic [15:0] mon_word, mon_sh;
    logic [15:0] uf_exp_cnt = '0;
    int          sd_bad = 0, rdy_bad = 0, uf_bad = 0, mon_slot;
    logic        exp_sd, exp_uf;
    stereo_t     popped;

    task automatic monitor_clear();
        exp_l = '0; exp_r = '0; obs_l = '0; obs_r = '0;
        sd_bad = 0; rdy_bad = 0; uf_bad = 0;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon_slot = int'(tb_cnt[9:5]);
            mon_word = tb_cnt[10] ? exp_r : exp_l;
            mon_sh   = mon_word >> (16 - mon_slot);
            exp_sd   = (mon_slot >= 1 && mon_slot <= 16) ? mon_sh[0] : 1'b0;
            if (sdata !== exp_sd) sd_bad++;
            if (tb_cnt[4:0] == 5'd16 && mon_slot >= 1 && mon_slot <= 16) begin
                if (tb_cnt[10]) obs_r = {obs_r[14:0], sdata};
                else            obs_l = {obs_l[14:0], sdata};
            end
            if (s_ready !== (sb_q.size() == 0)) rdy_bad++;
            if (tb_cnt != 11'd2047 && underflow !== 1'b0) uf_bad++;
            if (tb_cnt == 11'd2047) begin
                exp_uf = (sb_q.size() == 0);
                check("underflow_at_frame_end", underflow, exp_uf);
                check("left_word", obs_l, exp_l);
                check("right_word", obs_r, exp_r);
                check("sdata_bad_cycles", sd_bad, 0);
                check("s_ready_bad_cycles", rdy_bad, 0);
                check("underflow_spurious_cycles", uf_bad, 0);
                sd_bad = 0; rdy_bad = 0; uf_bad = 0; obs_l = '0; obs_r = '0;
                if (exp_uf) begin
                    exp_l = '0; exp_r = '0;
                    if (uf_exp_cnt != 16'hFFFF) uf_exp_cnt = uf_exp_cnt + 16'd1;
                end else begin
                    popped = sb_q.pop_front();
                    exp_l  = popped.l;
                    exp_r  = popped.r;
                end
            end
        end
    end

    task automatic push_pair(input logic [15:0] l, input logic [15:0] r);
        stereo_t p;
        p.l = l;
        p.r = r;
        sb_q.push_back(p);
    endtask

    // Returns at the negedge where the frame position equals target.
    task automatic wait_cnt(input int target);
        int n = 0;
        @(negedge clk);
        while (int'(tb_cnt) != target && n < 4096) begin
            @(negedge clk);
            n++;
        end
        if (n >= 4096) check("wait_cnt_timeout", 0, 1);
    endtask

    task automatic send(input logic [15:0] l, input logic [15:0] r);
        int n = 0;
        while (s_ready !== 1'b1 && n < 4096) begin
            @(negedge clk);
            n++;
        end
        if (n >= 4096) begin
            check("send_ready_timeout", s_ready, 1);
        end else begin
            s_left = l; s_right = r; s_valid = 1'b1;
            @(posedge clk);
            push_pair(l, r);
            @(negedge clk);
            s_valid = 1'b0;
        end
    endtask

    task automatic stream(input int cycles, output int xfers);
        logic acc;
        xfers = 0;
        s_valid = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            if (i != 0) @(negedge clk);
            s_left  = 16'($urandom_range(0, 65535));
            s_right = 16'($urandom_range(0, 65535));
            acc = s_ready;
            @(posedge clk);
            if (acc) begin
                push_pair(s_left, s_right);
                xfers++;
            end
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic clock_check();
        int m_bad = 0, s_bad = 0, l_bad = 0;
        for (int i = 0; i < 2048; i++) begin
            @(negedge clk);
            if (mclk !== ((int'(tb_cnt) % 8) >= 4))    m_bad++;
            if (sclk !== ((int'(tb_cnt) % 32) >= 16))  s_bad++;
            if (lrck !== (int'(tb_cnt) >= 1024))       l_bad++;
        end
        check("mclk_wave_bad_cycles", m_bad, 0);
        check("sclk_wave_bad_cycles", s_bad, 0);
        check("lrck_wave_bad_cycles", l_bad, 0);
    endtask

    initial begin
        #(10 * 60000);
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    int xfers;

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_left = '0; s_right = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_mclk", mclk, 0);
        check("rst_sclk", sclk, 0);
        check("rst_lrck", lrck, 0);
        check("rst_sdata", sdata, 0);
        check("rst_underflow", underflow, 0);
        check("rst_s_ready", s_ready, 1);
        monitor_clear();
        mon_en = 1'b1;

        clock_check();

        // Known pair: plays in the next frame, then an empty boundary mutes.
        wait_cnt(100);
        send(16'hA5C3, 16'h0001);
        wait_cnt(2047);
        wait_cnt(2047);
        wait_cnt(2047);

        // First valid exactly on the frame-end cycle with hold empty.
        check("ready_at_frame_end", s_ready, 1);
        check("underflow_with_accept", underflow, 1);
        s_left = 16'h7FFE; s_right = 16'h8001; s_valid = 1'b1;
        @(posedge clk);
        push_pair(16'h7FFE, 16'h8001);
        @(negedge clk);
        s_valid = 1'b0;
        check("ready_low_after_accept", s_ready, 0);
        wait_cnt(2047);
        wait_cnt(2047);

`ifdef I2S_TX_UNDERFLOW_CNT_EN
        wait_cnt(5);
        check("underflow_cnt", underflow_cnt, uf_exp_cnt);
`endif

        // Continuous valid: one transfer per frame, no underflow.
        wait_cnt(10);
        stream(3 * 2048, xfers);
        check("stream_transfers", xfers, 4);
        wait_cnt(2047);
        wait_cnt(2047);

        // One-cycle reset in the middle of a transfer.
        wait_cnt(600);
        mon_en = 1'b0;
        rst = 1'b1; s_valid = 1'b1; s_left = 16'h1234; s_right = 16'h5678;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; s_valid = 1'b0;
        check("midrst_mclk", mclk, 0);
        check("midrst_sclk", sclk, 0);
        check("midrst_lrck", lrck, 0);
        check("midrst_sdata", sdata, 0);
        check("midrst_underflow", underflow, 0);
        check("midrst_s_ready", s_ready, 1);
        check("midrst_cnt_model", tb_cnt, 0);
`ifdef I2S_TX_UNDERFLOW_CNT_EN
        check("midrst_underflow_cnt", underflow_cnt, 0);
`endif
        sb_q.delete();
        uf_exp_cnt = '0;
        #1;
        monitor_clear();
        mon_en = 1'b1;

        clock_check();
        wait_cnt(2047);
        @(negedge clk);
`ifdef I2S_TX_UNDERFLOW_CNT_EN
        check("underflow_cnt_after_rst", underflow_cnt, uf_exp_cnt);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
